// File: rtl/rx_frame_checker.sv
// -----------------------------------------------------------------------------
// rx_frame_checker
//
// UART RX bit checker. Checks the start, parity and stop bits of each frame,
// once per bit, at the mid-bit sample point. It keeps sticky error status and,
// optionally, saturating error counters.
//
// Build option:
//   RX_ERR_CNT_EN  defined   -> par_err_cnt / frm_err_cnt are real counters
//                  undefined -> no counter registers, both ports tied to 0
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   sampled_bit  bit value from the RX sampler
//   prescale     oversampling ratio (8, 16 or 32)
//   edge_cnt     edge position within the current bit
//   data         deserialized payload (used only in the parity evaluation)
//   PAR_TYP      00 even, 01 odd, 10 mark, 11 space
//   strt_chk_en  RX FSM is in the start-bit state
//   par_chk_en   RX FSM is in the parity-bit state
//   stp_chk_en   RX FSM is in the stop-bit state
//   err_clr      one-cycle pulse: clears flags, sticky status and counters
//   strt_glitch  last start check saw 1
//   par_err      last parity check mismatched
//   stp_err      last stop check saw 0
//   frame_done   one-cycle pulse after each stop evaluation
//   frame_ok     valid with frame_done; frame had no error
//   err_status   sticky {stp, par, strt} error bits
//   par_err_cnt  saturating parity error count
//   frm_err_cnt  saturating framing (stop) error count
// -----------------------------------------------------------------------------
module rx_frame_checker #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6,
   parameter int EDGE_CNT_WIDTH = 6,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      sampled_bit,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic [EDGE_CNT_WIDTH-1:0] edge_cnt,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic [1:0]                PAR_TYP,
   input  logic                      strt_chk_en,
   input  logic                      par_chk_en,
   input  logic                      stp_chk_en,
   input  logic                      err_clr,
   output logic                      strt_glitch,
   output logic                      par_err,
   output logic                      stp_err,
   output logic                      frame_done,
   output logic                      frame_ok,
   output logic [2:0]                err_status,
   output logic [ERR_CNT_WIDTH-1:0]  par_err_cnt,
   output logic [ERR_CNT_WIDTH-1:0]  frm_err_cnt
);

   localparam int SP_W  = PRESCALE_WIDTH + 1;
   localparam int CMP_W = (SP_W > EDGE_CNT_WIDTH) ? SP_W : EDGE_CNT_WIDTH;

   // One extra bit so (prescale>>1)+2 can never wrap.
   logic [SP_W-1:0] sample_pt;
   logic            at_sample;

   assign sample_pt = ({1'b0, prescale} >> 1) + SP_W'(2);
   assign at_sample = (CMP_W'(edge_cnt) == CMP_W'(sample_pt));

   // Check index: 0 = start, 1 = parity, 2 = stop.
   logic [2:0] chk_en;
   logic [2:0] cand;
   logic [2:0] eval;
   logic [2:0] armed_reg, armed_next;

   assign chk_en = {stp_chk_en, par_chk_en, strt_chk_en};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_arm
         assign cand[gi] = chk_en[gi] & at_sample & armed_reg[gi];
         // Disarm on evaluation; re-arm only once the enable drops, so a
         // stalled edge_cnt cannot cause a second evaluation.
         assign armed_next[gi] = ~chk_en[gi] | (armed_reg[gi] & ~eval[gi]);
      end
   endgenerate

   // Fixed priority strt > par > stp; losers keep their armed latch.
   assign eval[0] = cand[0];
   assign eval[1] = cand[1] & ~cand[0];
   assign eval[2] = cand[2] & ~cand[1] & ~cand[0];

   // Expected parity bit
   logic exp_par;
   always_comb begin
      exp_par = 1'b0;
      case (PAR_TYP)
         2'b00:   exp_par = ^data;
         2'b01:   exp_par = ~^data;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   logic par_mismatch;
   assign par_mismatch = sampled_bit ^ exp_par;

   logic       strt_glitch_reg, strt_glitch_next;
   logic       par_err_reg,     par_err_next;
   logic       stp_err_reg,     stp_err_next;
   logic       frame_done_reg,  frame_done_next;
   logic       frame_ok_reg,    frame_ok_next;
   logic       acc_reg,         acc_next;
   logic [2:0] status_reg,      status_next;
   logic [2:0] status_set;

   always_comb begin
      // err_clr wipes the flags first; an evaluation in the same cycle then
      // loads its result on top, so a new error survives the clear.
      strt_glitch_next = err_clr ? 1'b0 : strt_glitch_reg;
      par_err_next     = err_clr ? 1'b0 : par_err_reg;
      stp_err_next     = err_clr ? 1'b0 : stp_err_reg;
      frame_done_next  = 1'b0;
      frame_ok_next    = frame_ok_reg;
      acc_next         = acc_reg;
      status_set       = 3'b000;

      if (eval[0]) begin
         strt_glitch_next = sampled_bit;
         par_err_next     = 1'b0;
         stp_err_next     = 1'b0;
         acc_next         = sampled_bit;
         status_set[0]    = sampled_bit;
      end
      if (eval[1]) begin
         par_err_next  = par_mismatch;
         acc_next      = acc_reg | par_mismatch;
         status_set[1] = par_mismatch;
      end
      if (eval[2]) begin
         stp_err_next    = ~sampled_bit;
         frame_done_next = 1'b1;
         frame_ok_next   = ~(acc_reg | ~sampled_bit);
         acc_next        = 1'b0;
         status_set[2]   = ~sampled_bit;
      end

      status_next = (err_clr ? 3'b000 : status_reg) | status_set;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         armed_reg       <= 3'b111;
         strt_glitch_reg <= 1'b0;
         par_err_reg     <= 1'b0;
         stp_err_reg     <= 1'b0;
         frame_done_reg  <= 1'b0;
         frame_ok_reg    <= 1'b0;
         acc_reg         <= 1'b0;
         status_reg      <= 3'b000;
      end else begin
         armed_reg       <= armed_next;
         strt_glitch_reg <= strt_glitch_next;
         par_err_reg     <= par_err_next;
         stp_err_reg     <= stp_err_next;
         frame_done_reg  <= frame_done_next;
         frame_ok_reg    <= frame_ok_next;
         acc_reg         <= acc_next;
         status_reg      <= status_next;
      end
   end

   assign strt_glitch = strt_glitch_reg;
   assign par_err     = par_err_reg;
   assign stp_err     = stp_err_reg;
   assign frame_done  = frame_done_reg;
   assign frame_ok    = frame_ok_reg;
   assign err_status  = status_reg;

`ifdef RX_ERR_CNT_EN
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

   logic                     par_inc, frm_inc;
   logic [ERR_CNT_WIDTH-1:0] par_cnt_reg, par_cnt_next, par_cnt_base;
   logic [ERR_CNT_WIDTH-1:0] frm_cnt_reg, frm_cnt_next, frm_cnt_base;

   assign par_inc = eval[1] & par_mismatch;
   assign frm_inc = eval[2] & ~sampled_bit;

   always_comb begin
      par_cnt_base = err_clr ? '0 : par_cnt_reg;
      frm_cnt_base = err_clr ? '0 : frm_cnt_reg;
      par_cnt_next = (par_inc && (par_cnt_base != CNT_MAX)) ? par_cnt_base + CNT_ONE : par_cnt_base;
      frm_cnt_next = (frm_inc && (frm_cnt_base != CNT_MAX)) ? frm_cnt_base + CNT_ONE : frm_cnt_base;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         par_cnt_reg <= '0;
         frm_cnt_reg <= '0;
      end else begin
         par_cnt_reg <= par_cnt_next;
         frm_cnt_reg <= frm_cnt_next;
      end
   end

   assign par_err_cnt = par_cnt_reg;
   assign frm_err_cnt = frm_cnt_reg;
`else
   assign par_err_cnt = '0;
   assign frm_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// Testbench for rx_frame_checker: table of per-cycle vectors plus hand-written
// sequences for stall, saturation/clear and asynchronous reset.
module tb_rx_frame_checker;

   logic       CLK;
   logic       RST;
   logic       sampled_bit;
   logic [5:0] prescale;
   logic [5:0] edge_cnt;
   logic [7:0] data;
   logic [1:0] PAR_TYP;
   logic       strt_chk_en, par_chk_en, stp_chk_en, err_clr;
   logic       strt_glitch, par_err, stp_err, frame_done, frame_ok;
   logic [2:0] err_status;
   logic [1:0] par_err_cnt, frm_err_cnt;

   int total = 0;
   int bad   = 0;

   rx_frame_checker #(
      .DATA_WIDTH(8), .PRESCALE_WIDTH(6), .EDGE_CNT_WIDTH(6), .ERR_CNT_WIDTH(2)
   ) dut (
      .CLK(CLK), .RST(RST), .sampled_bit(sampled_bit), .prescale(prescale),
      .edge_cnt(edge_cnt), .data(data), .PAR_TYP(PAR_TYP),
      .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
      .err_clr(err_clr), .strt_glitch(strt_glitch), .par_err(par_err),
      .stp_err(stp_err), .frame_done(frame_done), .frame_ok(frame_ok),
      .err_status(err_status), .par_err_cnt(par_err_cnt), .frm_err_cnt(frm_err_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // {glitch, par_err, stp_err, done, ok, status[2:0], pcnt[1:0], fcnt[1:0]}
   typedef struct {
      logic        s, p, t, sb, clr;
      logic [5:0]  ec, ps;
      logic [7:0]  d;
      logic [1:0]  pt;
      logic [11:0] exp;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic s, input logic p, input logic t,
                               input logic sb, input logic [5:0] ec,
                               input logic [5:0] ps, input logic [7:0] d,
                               input logic [1:0] pt, input logic clr,
                               input logic [11:0] exp);
      vec_t v;
      v.s = s; v.p = p; v.t = t; v.sb = sb; v.ec = ec; v.ps = ps;
      v.d = d; v.pt = pt; v.clr = clr; v.exp = exp;
      return v;
   endfunction

   // Counters exist only in the RX_ERR_CNT_EN build; otherwise they read 0.
   function automatic int cnt_exp(input int v);
`ifdef RX_ERR_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   function automatic logic [11:0] outs();
      return {strt_glitch, par_err, stp_err, frame_done, frame_ok,
              err_status, par_err_cnt, frm_err_cnt};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("check %s: got %0d ok", name, act);
      end
   endtask

   task automatic drive(input logic s, input logic p, input logic t,
                        input logic sb, input logic [5:0] ec,
                        input logic [5:0] ps, input logic [7:0] d,
                        input logic [1:0] pt, input logic clr);
      @(negedge CLK);
      strt_chk_en = s; par_chk_en = p; stp_chk_en = t; sampled_bit = sb;
      edge_cnt = ec; prescale = ps; data = d; PAR_TYP = pt; err_clr = clr;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input logic [5:0] ps);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, ps, 8'h00, 2'b00, 1'b0);
   endtask

   initial begin
      logic [11:0] exp_v, act_v;

      RST = 1'b0; sampled_bit = 1'b0; prescale = 6'd8; edge_cnt = 6'd0;
      data = 8'h00; PAR_TYP = 2'b00; strt_chk_en = 1'b0; par_chk_en = 1'b0;
      stp_chk_en = 1'b0; err_clr = 1'b0;

      //             s     p     t     sb    ec     ps      d      pt     clr   g pe se fd fo st  pc fc
      vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd8,  8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd6,  6'd8,  8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'd7,  6'd8,  8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd8,  8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'd6,  6'd8,  8'hA5, 2'b00, 1'b0, 12'b0_1_0_0_0_010_01_00);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd8,  8'hA5, 2'b00, 1'b0, 12'b0_1_0_0_0_010_01_00);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd6,  6'd8,  8'h01, 2'b01, 1'b0, 12'b0_0_0_0_0_010_01_00);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd8,  8'h01, 2'b01, 1'b0, 12'b0_0_0_0_0_010_01_00);
      vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd6,  6'd8,  8'h01, 2'b10, 1'b0, 12'b0_1_0_0_0_010_10_00);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd8,  8'h01, 2'b10, 1'b0, 12'b0_1_0_0_0_010_10_00);
      vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd6,  6'd8,  8'h01, 2'b11, 1'b0, 12'b0_0_0_0_0_010_10_00);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd8,  8'h01, 2'b11, 1'b0, 12'b0_0_0_0_0_010_10_00);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd8,  8'h01, 2'b00, 1'b1, 12'b0_0_0_0_0_000_00_00);
      vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd9,  6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd11, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_1_1_000_00_00);
      vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_0_0_0_000_00_00);
      vecs[21] = mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_1_1_0_100_00_01);
      vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd16, 8'hA5, 2'b00, 1'b0, 12'b0_0_1_0_0_100_00_01);
      vecs[23] = mk(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b1_0_0_0_0_101_00_01);
      vecs[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b1_0_0_0_0_101_00_01);
      vecs[25] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd10, 6'd16, 8'hA5, 2'b00, 1'b0, 12'b1_0_0_1_0_101_00_01);
      vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd16, 8'hA5, 2'b00, 1'b0, 12'b1_0_0_0_0_101_00_01);
      vecs[27] = mk(1'b1, 1'b1, 1'b0, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b10, 1'b0, 12'b0_0_0_0_0_101_00_01);
      vecs[28] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd10, 6'd16, 8'hA5, 2'b10, 1'b0, 12'b0_1_0_0_0_111_01_01);
      vecs[29] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd16, 8'hA5, 2'b10, 1'b0, 12'b0_1_0_0_0_111_01_01);
      vecs[30] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd16, 8'hA5, 2'b00, 1'b1, 12'b0_0_0_0_0_000_00_00);

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_outputs", int'(outs()), 0);
      @(negedge CLK);
      RST = 1'b1;

      // Table-driven vectors: one clock per row, compared 1 time unit after the edge
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].sb, vecs[i].ec,
               vecs[i].ps, vecs[i].d, vecs[i].pt, vecs[i].clr);
         exp_v = vecs[i].exp;
         act_v = outs();
`ifndef RX_ERR_CNT_EN
         exp_v[3:0] = 4'b0000;
`endif
         // frame_ok only carries meaning alongside frame_done
         if (!exp_v[8]) begin
            exp_v[7] = 1'b0;
            act_v[7] = 1'b0;
         end
         total++;
         if (act_v !== exp_v) begin
            bad++;
            $display("FAIL row %0d: got %b expected %b", i, act_v, exp_v);
         end else begin
            $display("row %0d en=%b%b%b sb=%b ec=%0d ps=%0d pt=%b clr=%b out=%b ok",
                     i, vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].sb, vecs[i].ec,
                     vecs[i].ps, vecs[i].pt, vecs[i].clr, act_v);
         end
      end

      // Stall: parity enable held at the sample point for 5 cycles, mismatch
      repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd6, 6'd8, 8'hA5, 2'b10, 1'b0);
      idle(6'd8);
      chk("stall_par_err", int'(par_err), 1);
      chk("stall_status", int'(err_status), 2);
      chk("stall_par_cnt", int'(par_err_cnt), cnt_exp(1));

      // Saturation: clear, then 5 parity errors into a 2-bit counter
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd8, 8'hA5, 2'b00, 1'b1);
      chk("clr_par_cnt", int'(par_err_cnt), 0);
      chk("clr_status", int'(err_status), 0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd6, 6'd8, 8'hA5, 2'b10, 1'b0);
         idle(6'd8);
      end
      chk("sat_par_cnt", int'(par_err_cnt), cnt_exp(3));
      // err_clr coincident with a 6th error: the new error wins over the clear
      drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd6, 6'd8, 8'hA5, 2'b10, 1'b1);
      chk("clr_err_par_cnt", int'(par_err_cnt), cnt_exp(1));
      chk("clr_err_status1", int'(err_status[1]), 1);
      chk("clr_err_par_err", int'(par_err), 1);
      idle(6'd8);

      // Reset mid-frame: glitchy start, then reset asserted during the parity bit
      drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd6, 6'd8, 8'hA5, 2'b00, 1'b0);
      chk("mid_glitch", int'(strt_glitch), 1);
      @(negedge CLK);
      strt_chk_en = 1'b0; par_chk_en = 1'b1; sampled_bit = 1'b0;
      PAR_TYP = 2'b10; edge_cnt = 6'd6;
      #2;
      RST = 1'b0;
      #1;
      chk("async_reset_outputs", int'(outs()), 0);
      @(negedge CLK);
      RST = 1'b1;
      par_chk_en = 1'b0;

      // Clean frame at prescale 32 (sample point edge_cnt 18)
      drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd18, 6'd32, 8'hA5, 2'b00, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd18, 6'd32, 8'hA5, 2'b00, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd18, 6'd32, 8'hA5, 2'b00, 1'b0);
      chk("post_reset_done", int'(frame_done), 1);
      chk("post_reset_ok", int'(frame_ok), 1);
      chk("post_reset_status", int'(err_status), 0);
      idle(6'd32);
      chk("done_one_cycle", int'(frame_done), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_frame_checker.md
Name: rx_frame_checker

Overview:
- Next-generation UART RX bit checker. Replaces the single parity comparator with one block that checks the start, parity and stop bits.
- Parity modes are configurable (even/odd/mark/space). Each check is evaluated exactly once per bit.
- Error flags are sticky, and error counters saturate.
- Sits between the RX sampler/FSM and the register file. Consumes the sampled bit, the edge counter and the per-bit check enables from the RX FSM.

Parameters:
- DATA_WIDTH, 8, frame payload width in bits
- PRESCALE_WIDTH, 6, width of prescale input
- EDGE_CNT_WIDTH, 6, width of edge_cnt input
- ERR_CNT_WIDTH, 8, width of each saturating error counter

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous active-low reset
- sampled_bit  input  1  bit value from the RX sampler
- prescale  input  PRESCALE_WIDTH  oversampling ratio (8, 16 or 32)
- edge_cnt  input  EDGE_CNT_WIDTH  edge position within the current bit
- data  input  DATA_WIDTH  deserialized payload, stable while par_chk_en is high
- PAR_TYP  input  2  00 even, 01 odd, 10 mark, 11 space
- strt_chk_en  input  1  RX FSM is in the start-bit state
- par_chk_en  input  1  RX FSM is in the parity-bit state
- stp_chk_en  input  1  RX FSM is in the stop-bit state
- err_clr  input  1  one-cycle pulse; clears flags, sticky status and counters
- strt_glitch  output  1  last start check saw 1
- par_err  output  1  last parity check mismatched
- stp_err  output  1  last stop check saw 0
- frame_done  output  1  one-cycle pulse after each stop evaluation
- frame_ok  output  1  valid with frame_done; high when the frame had no error
- err_status  output  3  sticky {stp, par, strt} error bits
- par_err_cnt  output  ERR_CNT_WIDTH  saturating parity error count
- frm_err_cnt  output  ERR_CNT_WIDTH  saturating stop (framing) error count

Behaviour:
- Reset: every output is 0. All three per-check armed latches are set to 1. The frame-error accumulator is 0.
- Sample point: edge_cnt == (prescale>>1) + 2, computed at PRESCALE_WIDTH+1 bits so nothing is truncated.
- Evaluation (eval_x) for check x requires all three of:
  - x_chk_en high
  - sample point reached
  - armed_x set
- After eval_x:
  - armed_x clears in the same edge.
  - armed_x re-sets on the first cycle x_chk_en is low.
  - Each check is therefore evaluated at most once per enable assertion, even if edge_cnt stalls.
- Multiple enables high in the same cycle: priority strt > par > stp. Only the winner is evaluated; the losers stay armed.
- Expected parity: even = ^data, odd = ~^data, mark = 1, space = 0.
- All flags are registered; each updates on the edge following its evaluation cycle (latency 1).
- strt eval:
  - strt_glitch <= sampled_bit.
  - par_err and stp_err clear; this starts a new frame.
  - Frame accumulator <= sampled_bit.
- par eval:
  - par_err <= (sampled_bit != expected).
  - Accumulator ORs in the result.
- stp eval:
  - stp_err <= ~sampled_bit.
  - frame_done pulses for exactly one cycle.
  - frame_ok <= ~(accumulator | ~sampled_bit).
  - Accumulator clears.
- Outside evaluations, flags hold their value; unlike the previous checker, they do not fall back to 0 each cycle.
- err_status[i] sets whenever the corresponding flag is loaded with 1, and holds until err_clr.
- Counters:
  - par_err_cnt +1 on a par eval with mismatch.
  - frm_err_cnt +1 on a stp eval with sampled_bit = 0.
  - Both saturate at all-ones; no wrap.
- err_clr in the same cycle as an evaluation:
  - The clear applies first, then the new result, so set dominates.
  - A counter becomes 1 if that evaluation errs, otherwise 0.
  - err_clr does not affect the armed latches or the accumulator.
- A frame aborted by the RX FSM with no stop eval produces no frame_done. The next strt eval restarts the accumulator.
- PAR_TYP and data are sampled only in the par eval cycle; changes at other times have no effect.
- Reset asserted mid-frame returns the block to the reset state immediately (asynchronous).

Optional Feature:
- Macro: RX_ERR_CNT_EN.
- Defined: par_err_cnt and frm_err_cnt are implemented as described above.
- Undefined: no counter registers are built. Both counter ports remain and are tied to 0. Every other behaviour is unchanged.

Test Plan:
- Even parity: prescale=8, data=8'hA5, PAR_TYP=00, par_chk_en high, sampled_bit=0 at edge_cnt=6 -> par_err=0 next cycle. Repeat with sampled_bit=1 -> par_err=1, err_status=3'b010, par_err_cnt=1.
- Mark/space/odd: data=8'h01, PAR_TYP=01, sampled_bit=0 -> no error. PAR_TYP=10, sampled_bit=0 -> par_err=1. PAR_TYP=11, sampled_bit=0 -> par_err=0.
- Full frame at prescale=16 (sample at edge_cnt=10): strt 0, parity correct, stop 1 -> frame_done pulses one cycle with frame_ok=1. Same frame with stop 0 -> stp_err=1, frame_ok=0, frm_err_cnt=1.
- Stall/once-only: hold edge_cnt=6 for 5 cycles with par_chk_en high and mismatching parity -> par_err_cnt increments by exactly 1.
- Saturation/clear: ERR_CNT_WIDTH=2, inject 5 parity errors -> par_err_cnt=3. err_clr together with a 6th error -> par_err_cnt=1 and err_status[1]=1.
- Reset mid-frame: assert RST low during the parity bit -> all outputs 0 immediately. After release, a clean frame gives frame_ok=1.
